// File: rtl/rgb_ctrl_pkg.sv
// rtl/rgb_ctrl_pkg.sv - shared types and widths for rgb_ctrl and rgb_palette
`include "define.v"

package rgb_ctrl_pkg;

    localparam int ADC_W      = `ADC_WIDHT;
    localparam int VGA_W      = `VGA_WIDHT;
    localparam int MODE_W     = `MODE_MAX + 1;
    localparam int CNT_W      = `PIX_CNT_W;
    localparam int FRAME_PIX  = `FRAME_PIXELS;

    // IDLE: no frame seen yet, RUN: streaming, PEND: mode change waiting for a frame boundary
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    typedef logic [MODE_W-1:0] mode_t;

    typedef struct packed {
        logic [VGA_W-1:0] r;
        logic [VGA_W-1:0] g;
        logic [VGA_W-1:0] b;
    } rgb_t;

    // Grayscale level is simply the most significant VGA_W bits of the sample
    function automatic logic [VGA_W-1:0] gray_of(input logic [ADC_W-1:0] d);
        return d[ADC_W-1 -: VGA_W];
    endfunction

endpackage

// File: rtl/define.v
// rtl/define.v - shared sizing and mode-bit definitions for the rgb_ctrl slice
`ifndef RGB_CTRL_DEFINE_V
`define RGB_CTRL_DEFINE_V

`define ADC_WIDHT    12
`define VGA_WIDHT    6
`define MODE_MAX     1
`define MODE_RGB     0
`define MODE_TEST    1
`define PIX_CNT_W    8
`define FRAME_PIXELS 16

`endif

// File: rtl/rgb_ctrl_palette.sv
// rtl/rgb_ctrl_palette.sv - combinational colour mapping (pseudo-colour palette under PSEUDO_COLOR_EN)
`include "define.v"

module rgb_palette
    import rgb_ctrl_pkg::*;
(
    input  logic [ADC_W-1:0] pixel,
    input  mode_t            mode,
    output rgb_t             color
);

`ifdef PSEUDO_COLOR_EN
    // Four-segment ramp over the top 8 bits: blue -> magenta -> orange-ish -> white-ish
    function automatic rgb_t pseudo(input logic [ADC_W-1:0] d);
        logic [7:0] t;
        logic [1:0] s;
        logic [5:0] f;
        rgb_t       c;
        t = d[ADC_W-1 -: 8];
        s = t[7:6];
        f = t[5:0];
        c = '0;
        case (s)
            2'd0: begin
                c.b = VGA_W'(f);
            end
            2'd1: begin
                c.r = VGA_W'(f);
                c.b = VGA_W'(6'd63);
            end
            2'd2: begin
                c.r = VGA_W'(6'd63);
                c.g = VGA_W'(f);
                c.b = VGA_W'(6'd63 - f);
            end
            default: begin
                c.r = VGA_W'(6'd63);
                c.g = VGA_W'(6'd63);
                c.b = VGA_W'(f);
            end
        endcase
        return c;
    endfunction
`endif

    // Not every sample or mode bit feeds the mapping in every build
    logic unused_bits;
    assign unused_bits = ^{pixel, mode};

    // Test pattern beats pseudo-colour, which beats grayscale
    always_comb begin
        color = '0;
        if (mode[`MODE_TEST]) begin
            color.r = '1;
        end
`ifdef PSEUDO_COLOR_EN
        else if (mode[`MODE_RGB]) begin
            color = pseudo(pixel);
        end
`endif
        else begin
            color.r = gray_of(pixel);
            color.g = gray_of(pixel);
            color.b = gray_of(pixel);
        end
    end

endmodule

// File: rtl/rgb_ctrl.sv
// rtl/rgb_ctrl.sv - ADC-to-VGA colour pipeline with frame-aligned mode switching (palette option PSEUDO_COLOR_EN)
`include "define.v"

module rgb_ctrl
    import rgb_ctrl_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic [ADC_W-1:0] DATA_IN,
    input  logic             DATA_VALID,
    input  logic             FRAME_START,
    input  mode_t            MODE_REQ,
    input  logic             MODE_REQ_STB,
    output logic             MODE_ACK,
    output mode_t            MODE_ACTIVE,
    output logic [VGA_W-1:0] RED,
    output logic [VGA_W-1:0] GREEN,
    output logic [VGA_W-1:0] BLUE,
    output logic             PIX_VALID,
    output logic             FRAME_ERR
);

    state_t           state;
    mode_t            pend_mode;
    logic             pend_vld;
    logic [CNT_W-1:0] pix_cnt;

    logic             s1_vld;
    logic [ADC_W-1:0] s1_data;
    mode_t            s1_mode;
    rgb_t             s1_color;

    // A strobe in the same cycle as FRAME_START counts as already pending
    logic  pend_any;
    mode_t pend_next;
    logic  apply;
    mode_t pix_mode;
    logic  in_frame;
    logic  accept;

    assign pend_any  = MODE_REQ_STB | pend_vld;
    assign pend_next = MODE_REQ_STB ? MODE_REQ : pend_mode;
    assign apply     = FRAME_START & pend_any;
    assign pix_mode  = apply ? pend_next : MODE_ACTIVE;
    assign in_frame  = (state != ST_IDLE);
    assign accept    = DATA_VALID & (in_frame | FRAME_START);

    // Mode request FSM: latch requests, apply them only at a frame boundary
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            MODE_ACTIVE <= '0;
            pend_mode   <= '0;
            pend_vld    <= 1'b0;
            MODE_ACK    <= 1'b0;
        end else begin
            MODE_ACK <= 1'b0;
            if (FRAME_START) begin
                state <= ST_RUN;
                if (apply) begin
                    MODE_ACTIVE <= pend_next;
                    MODE_ACK    <= 1'b1;
                    pend_vld    <= 1'b0;
                end
            end else if (MODE_REQ_STB) begin
                pend_mode <= MODE_REQ;
                pend_vld  <= 1'b1;
                if (state == ST_RUN) begin
                    state <= ST_PEND;
                end
            end
        end
    end

    // Per-frame pixel count with sticky mismatch flag checked at each frame boundary
    always_ff @(posedge CLK) begin
        if (RST) begin
            pix_cnt   <= '0;
            FRAME_ERR <= 1'b0;
        end else if (FRAME_START) begin
            if (in_frame && (pix_cnt != CNT_W'(FRAME_PIX))) begin
                FRAME_ERR <= 1'b1;
            end
            pix_cnt <= DATA_VALID ? CNT_W'(1) : '0;
        end else if (in_frame && DATA_VALID && (pix_cnt != {CNT_W{1'b1}})) begin
            pix_cnt <= pix_cnt + CNT_W'(1);
        end
    end

    // Stage 1: capture sample together with the mode it must be rendered in
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
            s1_mode <= '0;
        end else begin
            s1_vld  <= accept;
            s1_data <= DATA_IN;
            s1_mode <= pix_mode;
        end
    end

    rgb_palette u_palette (
        .pixel (s1_data),
        .mode  (s1_mode),
        .color (s1_color)
    );

    // Stage 2: register colour, forcing black whenever no pixel is presented
    always_ff @(posedge CLK) begin
        if (RST) begin
            PIX_VALID <= 1'b0;
            RED       <= '0;
            GREEN     <= '0;
            BLUE      <= '0;
        end else begin
            PIX_VALID <= s1_vld;
            RED       <= s1_vld ? s1_color.r : '0;
            GREEN     <= s1_vld ? s1_color.g : '0;
            BLUE      <= s1_vld ? s1_color.b : '0;
        end
    end

endmodule

// File: tb/tb_rgb_ctrl.sv
// tb/tb_rgb_ctrl.sv - self-checking bench for rgb_ctrl
`timescale 1ns/1ps

module tb_rgb_ctrl;

    localparam int NCYC = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] data_in;
    logic        data_valid;
    logic        frame_start;
    logic [1:0]  mode_req;
    logic        mode_req_stb;
    logic        mode_ack;
    logic [1:0]  mode_active;
    logic [5:0]  red;
    logic [5:0]  green;
    logic [5:0]  blue;
    logic        pix_valid;
    logic        frame_err;

    rgb_ctrl dut (
        .CLK          (clk),
        .RST          (rst),
        .DATA_IN      (data_in),
        .DATA_VALID   (data_valid),
        .FRAME_START  (frame_start),
        .MODE_REQ     (mode_req),
        .MODE_REQ_STB (mode_req_stb),
        .MODE_ACK     (mode_ack),
        .MODE_ACTIVE  (mode_active),
        .RED          (red),
        .GREEN        (green),
        .BLUE         (blue),
        .PIX_VALID    (pix_valid),
        .FRAME_ERR    (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [18:0] e_pix [NCYC];
    logic [3:0]  e_ctl [NCYC];
    bit          c_pix [NCYC];
    bit          c_ctl [NCYC];

    int n_cmp = 0;
    int n_bad = 0;

    bit m_seen;
    bit m_has;
    bit m_err;
    int m_pend;
    int m_mode;
    int m_cnt;

    int rgb_exp_c;

    function automatic logic [17:0] ref_color(input int d, input int m);
        int r, g, b;
        r = 0; g = 0; b = 0;
        if ((m & 2) != 0) begin
            r = 63;
        end
`ifdef PSEUDO_COLOR_EN
        else if ((m & 1) != 0) begin
            int t, s, f;
            t = (d >> 4) & 255;
            s = t / 64;
            f = t % 64;
            case (s)
                0: b = f;
                1: begin r = f; b = 63; end
                2: begin r = 63; g = f; b = 63 - f; end
                default: begin r = 63; g = 63; b = f; end
            endcase
        end
`endif
        else begin
            r = (d >> 6) & 63;
            g = r;
            b = r;
        end
        return {r[5:0], g[5:0], b[5:0]};
    endfunction

    task automatic model(input int k, input bit r, input bit fs, input bit dv,
                         input int d, input bit s, input int rq);
        bit ack;
        bit take;
        if (k + 2 >= NCYC) return;
        if (r) begin
            m_seen = 0; m_has = 0; m_err = 0; m_pend = 0; m_mode = 0; m_cnt = 0;
            e_ctl[k+1] = 4'd0; c_ctl[k+1] = 1;
            e_pix[k+1] = 19'd0; c_pix[k+1] = 1;
            e_pix[k+2] = 19'd0; c_pix[k+2] = 1;
            return;
        end
        ack = 0;
        if (s) begin
            m_pend = rq;
            m_has  = 1;
        end
        if (fs) begin
            if (m_seen && m_cnt != 16) m_err = 1;
            if (m_has) begin
                m_mode = m_pend;
                m_has  = 0;
                ack    = 1;
            end
            m_seen = 1;
            m_cnt  = dv ? 1 : 0;
        end else if (m_seen && dv && m_cnt < 255) begin
            m_cnt = m_cnt + 1;
        end
        take = dv && m_seen;
        e_pix[k+2] = take ? {1'b1, ref_color(d, m_mode)} : 19'd0;
        c_pix[k+2] = 1;
        e_ctl[k+1] = {ack, m_mode[1:0], m_err};
        c_ctl[k+1] = 1;
    endtask

    task automatic step(input bit r, input bit fs, input bit dv,
                        input int d, input bit s, input int rq);
        rst          = r;
        frame_start  = fs;
        data_valid   = dv;
        data_in      = d[11:0];
        mode_req_stb = s;
        mode_req     = rq[1:0];
        model(cyc, r, fs, dv, d & 'hFFF, s, rq);
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // n pixels starting with FRAME_START; optional strobes at fs and at pixel indices sa/sb
    task automatic frame(input int n, input int d0, input int sd,
                         input bit fs_stb, input int fs_req,
                         input int sa, input int ra, input int sb, input int rb);
        int  d;
        bit  s;
        int  rq;
        for (int i = 0; i < n; i++) begin
            d  = (d0 + i * sd) & 'hFFF;
            s  = (i == sa) || (i == sb) || (i == 0 && fs_stb);
            rq = (i == 0 && fs_stb) ? fs_req : ((i == sb) ? rb : ra);
            step(0, i == 0, 1, d, s, rq);
            if (i % 5 == 4) step(0, 0, 0, d ^ 'h555, 0, 0);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < NCYC) begin
            if (c_ctl[cyc]) begin
                n_cmp++;
                if ({mode_ack, mode_active, frame_err} !== e_ctl[cyc]) begin
                    n_bad++;
                    $display("FAIL ctl cyc %0d: ack/mode/err got %b want %b", cyc,
                             {mode_ack, mode_active, frame_err}, e_ctl[cyc]);
                end
            end
            if (c_pix[cyc]) begin
                n_cmp++;
                if ({pix_valid, red, green, blue} !== e_pix[cyc]) begin
                    n_bad++;
                    $display("FAIL pix cyc %0d: valid/rgb got %h want %h", cyc,
                             {pix_valid, red, green, blue}, e_pix[cyc]);
                end
            end
        end
    end

    initial begin
        rst = 1; data_in = 0; data_valid = 0; frame_start = 0; mode_req = 0; mode_req_stb = 0;
`ifdef PSEUDO_COLOR_EN
        rgb_exp_c = 'h3F03F;
        lit("model_pseudo_800", ref_color('h800, 1), 'h3F03F);
        lit("model_pseudo_f00", ref_color('hF00, 1), 'h3FFF0);
`else
        rgb_exp_c = 'h20820;
        lit("model_rgbbit_800", ref_color('h800, 1), 'h20820);
        lit("model_rgbbit_f00", ref_color('hF00, 1), 'h3CF3C);
`endif
        lit("model_gray_fc0", ref_color('hFC0, 0), 'h3FFFF);
        lit("model_test_800", ref_color('h800, 2), 'h3F000);

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        lit("reset_err", frame_err, 0);
        lit("reset_mode", mode_active, 0);

        // pixels before the first frame are dropped
        step(0, 0, 1, 'h123, 0, 0);
        step(0, 0, 1, 'hABC, 0, 0);

        // frame A: grayscale full-scale
        frame(16, 'hFC0, 0, 0, 0, -1, 0, -1, 0);
        // frame B: RGB requested mid-frame, stays grayscale
        frame(16, 'h800, 0, 0, 0, 5, 1, -1, 0);

        // frame C: RGB applied at FRAME_START, then two requests while pending
        step(0, 1, 1, 'h800, 0, 0);
        lit("c_ack", mode_ack, 1);
        lit("c_active", mode_active, 1);
        step(0, 0, 1, 'h800, 0, 0);
        lit("c_first_rgb", {red, green, blue}, rgb_exp_c);
        for (int i = 2; i < 16; i++) begin
            step(0, 0, 1, ('h800 + i * 'h0B3) & 'hFFF, (i == 3) || (i == 9), (i == 9) ? 2 : 1);
        end

        // frame D: last request (TEST) wins
        step(0, 1, 1, 'h800, 0, 0);
        lit("d_active", mode_active, 2);
        step(0, 0, 1, 'h801, 0, 0);
        lit("d_first_rgb", {red, green, blue}, 'h3F000);
        for (int i = 2; i < 16; i++) step(0, 0, 1, i * 'h0F1, 0, 0);

        // frame E: strobe coincident with FRAME_START
        frame(16, 'h000, 'h101, 1, 1, -1, 0, -1, 0);
        // frame F short, G and H correct
        frame(15, 'h3A0, 'h0C7, 0, 0, -1, 0, -1, 0);
        frame(16, 'h7E0, 'h0D3, 0, 0, -1, 0, -1, 0);
        frame(16, 'hC40, 'h0A9, 1, 0, -1, 0, -1, 0);
        step(0, 1, 0, 0, 0, 0);
        lit("err_sticky", frame_err, 1);

        // reset with pixels in flight
        step(0, 0, 1, 'hFFF, 0, 0);
        step(0, 0, 1, 'hFFF, 0, 0);
        step(1, 1, 1, 'hFFF, 1, 2);
        lit("rst_pv", pix_valid, 0);
        lit("rst_err", frame_err, 0);
        step(0, 0, 1, 'hFFF, 0, 0);
        lit("rst_pv2", pix_valid, 0);
        step(0, 0, 1, 'hF00, 1, 1);
        step(0, 0, 1, 'hF00, 0, 0);

        // IDLE request applied at first frame, then saturating long frame
        frame(16, 'hF00, 'h011, 0, 0, -1, 0, -1, 0);
        frame(300, 'h050, 'h035, 0, 0, -1, 0, -1, 0);
        frame(16, 'h200, 'h0E5, 0, 0, -1, 0, -1, 0);
        lit("err_long", frame_err, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rgb_ctrl.md
RGB_CTRL -- requirements
Module: rgb_ctrl

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset: CLK input 1 rising-edge clock; RST input 1 synchronous active-high reset.
REQ-002 DATA_IN input `ADC_WIDHT: ADC pixel sample.
REQ-003 DATA_VALID input 1: DATA_IN is valid this cycle.
REQ-004 FRAME_START input 1: one-cycle pulse, coincident with the first pixel of a frame.
REQ-005 MODE_REQ input `MODE_MAX+1: requested display mode.
REQ-006 MODE_REQ_STB input 1: one-cycle strobe qualifying MODE_REQ.
REQ-007 MODE_ACK output 1: one-cycle pulse when a requested mode becomes active.
REQ-008 MODE_ACTIVE output `MODE_MAX+1: currently applied mode.
REQ-009 RED, GREEN, BLUE outputs `VGA_WIDHT each: colour channels.
REQ-010 PIX_VALID output 1: RED/GREEN/BLUE are valid.
REQ-011 FRAME_ERR output 1: sticky pixel-count mismatch flag.

Function
REQ-012 The FSM SHALL have three states: IDLE (no frame seen), RUN, and PEND (mode request waiting for a frame boundary).
REQ-013 IDLE SHALL move to RUN on FRAME_START; pixels in IDLE SHALL be dropped, with PIX_VALID=0.
REQ-014 MODE_REQ_STB in RUN SHALL capture MODE_REQ into a pending register and go to PEND; a strobe in IDLE SHALL capture MODE_REQ and remain in IDLE.
REQ-015 In PEND, a further strobe SHALL overwrite the pending value (last request wins).
REQ-016 On FRAME_START with a pending request (IDLE or PEND): MODE_ACTIVE <= pending; MODE_ACK=1 the next cycle for exactly one cycle; state goes to RUN.
REQ-017 A strobe coincident with FRAME_START SHALL be applied at that FRAME_START.
REQ-018 The mode applied to the pixel accompanying FRAME_START SHALL be the new mode.
REQ-019 Pipeline latency SHALL be 2 cycles: stage 1 registers the sample and active mode; stage 2 registers colour and PIX_VALID.
REQ-020 PIX_VALID SHALL be DATA_VALID delayed by 2 cycles, excluding dropped IDLE pixels.
REQ-021 RED/GREEN/BLUE SHALL be 0 whenever PIX_VALID=0.
REQ-022 Colour priority SHALL be:
- MODE[`MODE_TEST]=1: R=all ones, G=0, B=0.
- Else MODE[`MODE_RGB]=1: pseudo-colour (REQ-023).
- Else grayscale: R=G=B=DATA_IN[`ADC_WIDHT-1:`ADC_WIDHT-`VGA_WIDHT].
REQ-023 Pseudo-colour SHALL use t = top 8 bits of DATA_IN, s = t[7:6], f = t[5:0]:
- s=0: (0, 0, f)
- s=1: (f, 0, 63)
- s=2: (63, f, 63-f)
- s=3: (63, 63, f)
REQ-024 A pixel counter (`PIX_CNT_W bits) SHALL increment on each DATA_VALID in RUN/PEND and saturate at its maximum.
REQ-025 On FRAME_START in RUN/PEND, if count != `FRAME_PIXELS, FRAME_ERR SHALL be set (sticky).
REQ-026 On every FRAME_START, the counter SHALL reload to 1 if DATA_VALID is high, else 0.

Reset
REQ-027 On RST, at the next edge the block SHALL set: state=IDLE; MODE_ACTIVE=0 (grayscale); pending cleared; MODE_ACK=0; PIX_VALID=0; RGB=0; FRAME_ERR=0; counter=0.
REQ-028 In-flight pipeline pixels SHALL be discarded on reset mid-frame.
REQ-029 RST SHALL override all simultaneous inputs.

Configuration
REQ-030 Macro PSEUDO_COLOR_EN:
- Defined: REQ-023 palette is compiled in.
- Undefined: MODE[`MODE_RGB] is ignored, grayscale is used in its place, and no palette logic is synthesised.
- MODE_ACTIVE still reflects the requested bits in both cases.

Structure
REQ-031 `ADC_WIDHT, `VGA_WIDHT, `MODE_MAX, `MODE_RGB, `MODE_TEST, `PIX_CNT_W and `FRAME_PIXELS SHALL live in the shared define.v.
REQ-032 The colour mapping SHALL be one combinational sub-module, rgb_palette (pixel + mode in, R/G/B out); FSM, counter and pipeline stay in rgb_ctrl.

Verification (ADC_WIDHT=12, VGA_WIDHT=6, FRAME_PIXELS=16)
REQ-033 Reset, then FRAME_START plus 16 valid pixels of 0xFC0 in grayscale -> PIX_VALID 2 cycles later, R=G=B=0x3F, FRAME_ERR=0.
REQ-034 Strobe MODE_RGB mid-frame, pixel 0x800 -> remainder of frame stays grayscale (0x20 each); at next FRAME_START MODE_ACK pulses once and pixel 0x800 -> (63, 0, 63).
REQ-035 Two strobes in PEND (RGB, then TEST) -> at FRAME_START MODE_ACTIVE=TEST and output (63, 0, 0); exactly one ACK.
REQ-036 Strobe coincident with FRAME_START -> that frame's first pixel uses the new mode; ACK the following cycle.
REQ-037 Frame with 15 pixels before next FRAME_START -> FRAME_ERR=1, held through later correct frames until RST.
REQ-038 RST asserted with 2 pixels in flight -> PIX_VALID=0, RGB=0, state IDLE; pixels before the next FRAME_START are dropped.
